calc_op_sequencer: RTL
======================

// Module: calc_op_sequencer
// PURPOSE
//  Sequences the SW-operand calculator: edge-detects active-low KEY requests and arbitrates them
//  (add/sub/mul), latches operands, then runs a multi-cycle shift-add-3 binary-to-BCD conversion.
//  Drives four registered BCD digit codes to the 7-segment decoders.
//  Replaces the single-cycle divide/modulo path with a fixed-latency FSM.
// PARAMETERS
//  OP_W             5   operand width; legal 2..6; SW = {a,b}, a = SW[2*OP_W-1:OP_W], b = SW[OP_W-1:0]
//  DEBOUNCE_CYCLES  16  stable cycles a key must hold before acceptance (KEY_DEBOUNCE_EN only)
// PORTS
//  clk      in   1        system clock, all logic on rising edge
//  rst      in   1        synchronous reset, active high
//  SW       in   2*OP_W   operands {a,b}, unsigned
//  KEY      in   3        active-low requests: [0]=a+b [1]=a-b [2]=a*b
//  busy     out  1        high from CALC through DONE inclusive
//  out_valid out 1        one-cycle pulse: new digits presented
//  op_code  out  2        op of last completed result: 0 add, 1 sub, 2 mul
//  neg      out  1        last result negative (sub with a<b)
//  dig3..dig0 out 4 each  digit codes, dig3 most significant; 0-9 decimal, 4'hA minus, 4'hB blank
// BEHAVIOUR
//  Reset: busy=0, out_valid=0, op_code=0, neg=0, dig3..dig0=0, FSM=IDLE.
//         Key history regs = 1 (released), so no spurious edge after reset.
//  Key path: key_q<=KEY; key_qq<=key_q; press[i] = key_qq[i] & ~key_q[i] (falling edge).
//  Arbitration: fixed priority KEY0 > KEY1 > KEY2 among presses in the same cycle.
//   Lower-priority presses in that cycle are dropped.
//  A press seen outside IDLE is discarded, not queued; a held key yields exactly one op.
//  FSM: IDLE --press--> CALC (latch a,b,op) --1 cyc--> CONV (2*OP_W cycles, cnt 0..2*OP_W-1)
//       --> DONE --1 cyc--> IDLE.
//  CALC: result width 2*OP_W, zero-extended.
//   add: r=a+b.  mul: r=a*b.
//   sub: a>=b -> r=a-b, neg=0;  a<b -> r=b-a, neg=1.
//  CONV: per cycle, add 3 to every BCD nibble >=5, then shift {bcd,r} left 1; 16-bit BCD accumulator.
//  DONE: out_valid=1; dig3..dig0/op_code/neg registered on the edge entering DONE; held until next DONE.
//   neg=0: dig3..dig0 = thousands..units.
//   neg=1: dig3=4'hA, dig2..dig0 = magnitude digits (magnitude < 2^OP_W, so dig2=0).
//  Latency: out_valid high in the cycle after the (2*OP_W+2)th rising edge following the edge
//   that first samples KEY low (12 for OP_W=5).
//  SW changes after CALC do not affect the running op.
//  rst mid-op aborts: next cycle IDLE, busy=0, digits=0, no out_valid.
// CONFIGURATION
//  KEY_DEBOUNCE_EN defined:
//   - per-key counter between KEY and key_q;
//   - filtered level follows raw only after raw differs from it for DEBOUNCE_CYCLES consecutive cycles;
//   - shorter glitches are ignored;
//   - latency grows by DEBOUNCE_CYCLES;
//   - counters reset to 0 and filtered level to 1.
//  KEY_DEBOUNCE_EN undefined: raw KEY feeds key_q directly; no counters are built.
// TESTING (OP_W=5)
//  1 rst; SW={5'd12,5'd7}; KEY0 low 3 cyc -> out_valid pulse at latency 12; digits 0,0,1,9; neg=0; op_code=0.
//  2 SW={5'd31,5'd31}; KEY2 press -> digits 0,9,6,1; op_code=2; busy high exactly 12 cycles.
//  3 SW={5'd3,5'd20}; KEY1 press -> digits A,0,1,7; neg=1; op_code=1. SW={20,3} -> 0,0,1,7; neg=0.
//  4 KEY0 and KEY2 fall in the same cycle -> only add result. KEY held 50 cycles -> exactly one out_valid.
//  5 KEY1 press in 5th CONV cycle -> ignored, only 1 pulse.
//    rst in CONV -> next cycle busy=0, digits 0, no pulse.
//  6 KEY_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle KEY0 glitch -> no op;
//    6-cycle low -> one op, latency 16.

Source files
------------

// File: rtl/calc_op_sequencer_if.sv
// Operand/key inputs and BCD result outputs of calc_op_sequencer.
// master = stimulus side (drives SW/KEY), slave = sequencer side.
interface calc_op_sequencer_if #(
  parameter int OP_W = 5
);
  logic [2*OP_W-1:0] SW;
  logic [2:0]        KEY;
  logic              busy;
  logic              out_valid;
  logic [1:0]        op_code;
  logic              neg;
  logic [3:0]        dig3;
  logic [3:0]        dig2;
  logic [3:0]        dig1;
  logic [3:0]        dig0;

  modport master (
    output SW, KEY,
    input  busy, out_valid, op_code, neg, dig3, dig2, dig1, dig0
  );

  modport slave (
    input  SW, KEY,
    output busy, out_valid, op_code, neg, dig3, dig2, dig1, dig0
  );
endinterface

// File: rtl/calc_op_sequencer.sv
// Key-driven add/sub/mul calculator with a multi-cycle shift-add-3 BCD conversion.
// Optional per-key debounce filter enabled by defining KEY_DEBOUNCE_EN.
module calc_op_sequencer #(
  parameter int OP_W            = 5,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  calc_op_sequencer_if.slave bus
);
  localparam int RW = 2 * OP_W;
  localparam int CW = $clog2(RW);

  if (OP_W < 2 || OP_W > 6 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("calc_op_sequencer: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

  state_t          state;
  logic [2:0]      key_in;
  logic [2:0]      key_q;
  logic [2:0]      key_qq;
  logic [2:0]      press;
  logic [OP_W-1:0] a_q;
  logic [OP_W-1:0] b_q;
  logic [1:0]      op_q;
  logic            neg_q;
  logic [RW-1:0]   r_q;
  logic [15:0]     bcd_q;
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   calc_r;
  logic            calc_neg;
  logic [15:0]     bcd_adj;
  logic [15:0]     bcd_nxt;
  logic [RW-1:0]   r_nxt;

`ifdef KEY_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [2:0]    key_filt;
  logic [DW-1:0] db_cnt [3];

  // Filtered level only flips after the raw key disagrees for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_filt <= '1;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (bus.KEY[i] == key_filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          key_filt[i] <= bus.KEY[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign key_in = key_filt;
`else
  assign key_in = bus.KEY;
`endif

  assign press = key_qq & ~key_q;

  always_comb begin
    calc_neg = 1'b0;
    case (op_q)
      2'd0:    calc_r = RW'(a_q) + RW'(b_q);
      2'd1: begin
        if (a_q >= b_q) begin
          calc_r = RW'(a_q - b_q);
        end else begin
          calc_r   = RW'(b_q - a_q);
          calc_neg = 1'b1;
        end
      end
      default: calc_r = RW'(a_q) * RW'(b_q);
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    {bcd_nxt, r_nxt} = {bcd_adj, r_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      key_q         <= '1;
      key_qq        <= '1;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      neg_q         <= 1'b0;
      r_q           <= '0;
      bcd_q         <= '0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.op_code   <= '0;
      bus.neg       <= 1'b0;
      bus.dig3      <= '0;
      bus.dig2      <= '0;
      bus.dig1      <= '0;
      bus.dig0      <= '0;
    end else begin
      key_q         <= key_in;
      key_qq        <= key_q;
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|press) begin
            state    <= CALC;
            bus.busy <= 1'b1;
            a_q      <= bus.SW[RW-1:OP_W];
            b_q      <= bus.SW[OP_W-1:0];
            op_q     <= press[0] ? 2'd0 : (press[1] ? 2'd1 : 2'd2);
          end
        end
        CALC: begin
          r_q   <= calc_r;
          neg_q <= calc_neg;
          bcd_q <= '0;
          cnt   <= '0;
          state <= CONV;
        end
        CONV: begin
          bcd_q <= bcd_nxt;
          r_q   <= r_nxt;
          cnt   <= cnt + 1'b1;
          // Digits are taken from the final shift's combinational result so they land with DONE.
          if (cnt == CW'(RW - 1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.op_code   <= op_q;
            bus.neg       <= neg_q;
            bus.dig3      <= neg_q ? 4'hA : bcd_nxt[15:12];
            bus.dig2      <= bcd_nxt[11:8];
            bus.dig1      <= bcd_nxt[7:4];
            bus.dig0      <= bcd_nxt[3:0];
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
